// File: rtl/mips_dlx_pkg.sv
// Shared definitions for the DLX back-end pipeline: control bundle layouts,
// ALU operation codes, R-type funct codes and the bubble (all-zero) controls.
package mips_dlx_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

  // EX_control = {RegDst, ALUSrc, ALUOp[1:0]}
  typedef struct packed {
    logic   reg_dst;
    logic   alu_src;
    aluop_e alu_op;
  } ex_ctrl_t;

  // M_control = {Branch, MemRead, MemWrite, BOP}; BOP=1 selects bne
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic bop;
  } m_ctrl_t;

  // WB_control = {RegWrite, MemtoReg}
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '0;
  localparam m_ctrl_t  M_BUBBLE  = '0;
  localparam wb_ctrl_t WB_BUBBLE = '0;

endpackage

// File: rtl/alu_dlx.sv
// Combinational DLX ALU: add/sub/or directly from ALUOp, R-type ops via funct.
module alu_dlx
  import mips_dlx_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  aluop_e             alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [DATA_W-1:0]  result,
  output logic               zero
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALUOP_ADD: result = a + b;
      ALUOP_SUB: result = a - b;
      ALUOP_OR:  result = a | b;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: result = a + b;
          FUNCT_SUB: result = a - b;
          FUNCT_AND: result = a & b;
          FUNCT_OR:  result = a | b;
          FUNCT_SLT: result = DATA_W'($signed(a) < $signed(b));
          default:   result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_writeback.sv
// EX, MEM and WB stages of the DLX pipeline with their pipeline registers,
// word-addressed data memory and taken-branch squash of the two younger slots.
module execute_writeback
  import mips_dlx_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_W = 8,
  parameter int unsigned PC_W        = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        EX_control,
  input  logic [3:0]        M_control,
  input  logic [1:0]        WB_control,
  input  logic [31:0]       busa,
  input  logic [31:0]       busb,
  input  logic [31:0]       immed_ext,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [PC_W-1:0]   PC_plus_1,
  output logic [31:0]       busw,
  output logic [4:0]        rw,
  output logic              reg_write,
  output logic              PC_sel,
  output logic [PC_W-1:0]   jump_address
);

  localparam int unsigned DMEM_DEPTH = 1 << DMEM_ADDR_W;

  // ID/EX
  ex_ctrl_t            idex_ex;
  m_ctrl_t             idex_m;
  wb_ctrl_t            idex_wb;
  logic [DATA_W-1:0]   idex_a, idex_b, idex_imm;
  logic [REG_W-1:0]    idex_rt, idex_rd;
  logic [FUNCT_W-1:0]  idex_funct;
  logic [PC_W-1:0]     idex_pc1;

  // EX/MEM
  m_ctrl_t             exmem_m;
  wb_ctrl_t            exmem_wb;
  logic [DATA_W-1:0]   exmem_result, exmem_store;
  logic                exmem_zero;
  logic [REG_W-1:0]    exmem_dest;
  logic [PC_W-1:0]     exmem_target;

  // MEM/WB
  wb_ctrl_t            memwb_wb;
  logic [DATA_W-1:0]   memwb_result, memwb_mem_data;
  logic [REG_W-1:0]    memwb_dest;

  logic [DATA_W-1:0]      ex_b, ex_result;
  logic                   ex_zero;
  logic [REG_W-1:0]       ex_dest;
  logic [PC_W-1:0]        ex_target;
  logic [DMEM_ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]      dmem [DMEM_DEPTH];

  // EX stage operand and destination selection
  always_comb begin
    ex_b      = idex_ex.alu_src ? idex_imm : idex_b;
    ex_dest   = idex_ex.reg_dst ? idex_rd : idex_rt;
    ex_target = idex_pc1 + idex_imm[PC_W-1:0];
  end

  alu_dlx u_alu (
    .a      (idex_a),
    .b      (ex_b),
    .alu_op (idex_ex.alu_op),
    .funct  (idex_funct),
    .result (ex_result),
    .zero   (ex_zero)
  );

  assign PC_sel       = exmem_m.branch & (exmem_zero ^ exmem_m.bop);
  assign jump_address = exmem_target;
  assign dmem_addr    = exmem_result[DMEM_ADDR_W-1:0];

  // ID/EX capture; a taken branch in MEM turns the incoming slot into a bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idex_ex    <= EX_BUBBLE;
      idex_m     <= M_BUBBLE;
      idex_wb    <= WB_BUBBLE;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
      idex_rt    <= '0;
      idex_rd    <= '0;
      idex_funct <= '0;
      idex_pc1   <= '0;
    end else begin
      idex_ex    <= PC_sel ? EX_BUBBLE : ex_ctrl_t'(EX_control);
      idex_m     <= PC_sel ? M_BUBBLE  : m_ctrl_t'(M_control);
      idex_wb    <= PC_sel ? WB_BUBBLE : wb_ctrl_t'(WB_control);
      idex_a     <= busa;
      idex_b     <= busb;
      idex_imm   <= immed_ext;
      idex_rt    <= rt;
      idex_rd    <= rd;
      idex_funct <= funct;
      idex_pc1   <= PC_plus_1;
    end
  end

  // EX/MEM capture; the instruction leaving EX is squashed on a taken branch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exmem_m      <= M_BUBBLE;
      exmem_wb     <= WB_BUBBLE;
      exmem_result <= '0;
      exmem_store  <= '0;
      exmem_zero   <= 1'b0;
      exmem_dest   <= '0;
      exmem_target <= '0;
    end else begin
      exmem_m      <= PC_sel ? M_BUBBLE  : idex_m;
      exmem_wb     <= PC_sel ? WB_BUBBLE : idex_wb;
      exmem_result <= ex_result;
      exmem_store  <= idex_b;
      exmem_zero   <= ex_zero;
      exmem_dest   <= ex_dest;
      exmem_target <= ex_target;
    end
  end

  // MEM/WB capture with synchronous memory read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memwb_wb       <= WB_BUBBLE;
      memwb_result   <= '0;
      memwb_mem_data <= '0;
      memwb_dest     <= '0;
    end else begin
      memwb_wb     <= exmem_wb;
      memwb_result <= exmem_result;
      memwb_dest   <= exmem_dest;
      if (exmem_m.mem_read) begin
        memwb_mem_data <= dmem[dmem_addr];
      end
    end
  end

  // Data memory contents survive reset
  always_ff @(posedge clock) begin
    if (exmem_m.mem_write) begin
      dmem[dmem_addr] <= exmem_store;
    end
  end

  assign busw      = memwb_wb.mem_to_reg ? memwb_mem_data : memwb_result;
  assign rw        = memwb_dest;
  assign reg_write = memwb_wb.reg_write;

endmodule

// File: tb/tb_execute_writeback.sv
// Self-checking bench for execute_writeback: directed scenarios plus a random
// instruction stream checked against an instruction-level reference model.
module tb_execute_writeback;

  logic        clock, reset;
  logic [3:0]  EX_control, M_control;
  logic [1:0]  WB_control;
  logic [31:0] busa, busb, immed_ext;
  logic [4:0]  rt, rd;
  logic [5:0]  funct;
  logic [9:0]  PC_plus_1;
  logic [31:0] busw;
  logic [4:0]  rw;
  logic        reg_write, PC_sel;
  logic [9:0]  jump_address;

  int vectors = 0;
  int miscompares = 0;

  execute_writeback #(.DMEM_ADDR_W(8), .PC_W(10)) dut (
    .clock(clock), .reset(reset), .EX_control(EX_control), .M_control(M_control),
    .WB_control(WB_control), .busa(busa), .busb(busb), .immed_ext(immed_ext),
    .rt(rt), .rd(rd), .funct(funct), .PC_plus_1(PC_plus_1), .busw(busw), .rw(rw),
    .reg_write(reg_write), .PC_sel(PC_sel), .jump_address(jump_address)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  ex;
    logic [3:0]  m;
    logic [1:0]  wb;
    logic [31:0] a, b, imm;
    logic [4:0]  rt, rd;
    logic [5:0]  funct;
    logic [9:0]  pc1;
  } ins_t;

  // Architectural outcome of one instruction
  typedef struct packed {
    logic        we, to_reg, rd_mem, wr_mem, taken, sq, ld_ok;
    logic [31:0] res, store, ld;
    logic [4:0]  dest;
    logic [9:0]  target;
    logic [7:0]  addr;
  } rec_t;

  rec_t        q[$];        // q[0]=MEM/WB, q[1]=EX/MEM, q[2]=ID/EX
  logic [31:0] mm[256];
  bit          mok[256];

  function automatic ins_t mk(input logic [3:0] ex, input logic [3:0] m, input logic [1:0] wb,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                              input logic [4:0] t, input logic [4:0] d, input logic [5:0] f,
                              input logic [9:0] pc1);
    ins_t i;
    i.ex = ex; i.m = m; i.wb = wb; i.a = a; i.b = b; i.imm = imm;
    i.rt = t; i.rd = d; i.funct = f; i.pc1 = pc1;
    return i;
  endfunction

  function automatic rec_t model(input ins_t i);
    rec_t r;
    logic [31:0] op2, res;
    r = '0;
    op2 = i.ex[2] ? i.imm : i.b;
    case (i.ex[1:0])
      2'd0: res = i.a + op2;
      2'd1: res = i.a - op2;
      2'd3: res = i.a | op2;
      default: begin
        if      (i.funct == 6'h20) res = i.a + op2;
        else if (i.funct == 6'h22) res = i.a - op2;
        else if (i.funct == 6'h24) res = i.a & op2;
        else if (i.funct == 6'h25) res = i.a | op2;
        else if (i.funct == 6'h2A) res = ($signed(i.a) < $signed(op2)) ? 32'd1 : 32'd0;
        else                       res = 32'd0;
      end
    endcase
    r.res    = res;
    r.dest   = i.ex[3] ? i.rd : i.rt;
    r.target = i.pc1 + i.imm[9:0];
    r.taken  = i.m[3] && ((res == 32'd0) != i.m[0]);
    r.rd_mem = i.m[2];
    r.wr_mem = i.m[1];
    r.addr   = res[7:0];
    r.store  = i.b;
    r.we     = i.wb[1];
    r.to_reg = i.wb[0];
    return r;
  endfunction

  task automatic reset_model();
    q = {};
    repeat (3) q.push_back(rec_t'('0));
  endtask

  // Drive one instruction, clock it in and advance the model by one edge
  task automatic step(input ins_t i);
    rec_t r, mw, nx;
    @(negedge clock);
    EX_control = i.ex; M_control = i.m; WB_control = i.wb;
    busa = i.a; busb = i.b; immed_ext = i.imm;
    rt = i.rt; rd = i.rd; funct = i.funct; PC_plus_1 = i.pc1;
    r = model(i);
    @(posedge clock);
    mw = q[1];
    if (!mw.sq) begin
      if (mw.rd_mem) begin
        mw.ld_ok = mok[mw.addr];
        mw.ld    = mm[mw.addr];
      end
      if (mw.wr_mem) begin
        mm[mw.addr]  = mw.store;
        mok[mw.addr] = 1'b1;
      end
      if (mw.taken) begin
        nx = q[2]; nx.sq = 1'b1; q[2] = nx;
        r.sq = 1'b1;
      end
    end
    q[1] = mw;
    q.push_back(r);
    void'(q.pop_front());
  endtask

  function automatic ins_t nop();
    return mk(4'b0, 4'b0, 2'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 6'd0, 10'd0);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    EX_control = 4'($urandom); M_control = 4'($urandom); WB_control = 2'($urandom);
    busa = $urandom; busb = $urandom; immed_ext = $urandom;
    rt = 5'($urandom); rd = 5'($urandom); funct = 6'($urandom); PC_plus_1 = 10'($urandom);
    #1;
    vectors++;
    if ({busw, rw, reg_write, PC_sel} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_initial: got busw=%h rw=%0d we=%b pcsel=%b, expected all 0", busw, rw, reg_write, PC_sel);
    end
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    reset_model();
    // Mid-operation: a taken beq sits in EX/MEM and an add sits in MEM/WB
    step(mk(4'b1010, 4'b0, 2'b10, 32'd3, 32'd4, 32'd0, 5'd0, 5'd9, 6'h20, 10'd0));
    step(mk(4'b0001, 4'b1000, 2'b0, 32'd7, 32'd7, 32'd3, 5'd0, 5'd0, 6'd0, 10'd50));
    step(nop());
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({busw, rw, reg_write, PC_sel, jump_address} !== 49'd0) begin
      miscompares++;
      $display("FAIL reset_async: got busw=%h rw=%0d we=%b pcsel=%b jump=%0d, expected all 0",
               busw, rw, reg_write, PC_sel, jump_address);
    end
    @(posedge clock);
    #2 reset = 1'b0;
    reset_model();
  endtask

  task automatic test_rtype();
    step(mk(4'b1010, 4'b0, 2'b10, 32'd5, 32'd7, 32'd0, 5'd1, 5'd3, 6'h20, 10'd0));
    step(mk(4'b1010, 4'b0, 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd8, 6'h2A, 10'd0));
    step(nop());
    #1;
    vectors++;
    if (busw !== 32'd12 || rw !== 5'd3 || reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL rtype_add: got busw=%0d rw=%0d we=%b, expected 12 3 1", busw, rw, reg_write);
    end
    step(nop());
    #1;
    vectors++;
    if (busw !== 32'd1 || rw !== 5'd8 || reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL rtype_slt: got busw=%0d rw=%0d we=%b, expected 1 8 1", busw, rw, reg_write);
    end
  endtask

  task automatic test_store_load();
    step(mk(4'b0100, 4'b0010, 2'b00, 32'd4, 32'hDEAD_BEEF, 32'd0, 5'd2, 5'd0, 6'd0, 10'd0));
    step(nop());
    step(nop());
    step(mk(4'b0100, 4'b0100, 2'b11, 32'd4, 32'd0, 32'd0, 5'd6, 5'd0, 6'd0, 10'd0));
    step(mk(4'b0100, 4'b0100, 2'b11, 32'd260, 32'd0, 32'd0, 5'd7, 5'd0, 6'd0, 10'd0));
    step(nop());
    #1;
    vectors++;
    if (busw !== 32'hDEAD_BEEF || rw !== 5'd6 || reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL load: got busw=%h rw=%0d we=%b, expected deadbeef 6 1", busw, rw, reg_write);
    end
    step(nop());
    #1;
    vectors++;
    if (busw !== 32'hDEAD_BEEF || rw !== 5'd7) begin
      miscompares++;
      $display("FAIL load_wrap: got busw=%h rw=%0d, expected deadbeef 7", busw, rw);
    end
  endtask

  task automatic test_branch_taken();
    ins_t add_i;
    add_i = mk(4'b1010, 4'b0, 2'b10, 32'd1, 32'd1, 32'd0, 5'd0, 5'd10, 6'h20, 10'd0);
    step(mk(4'b0001, 4'b1000, 2'b00, 32'd9, 32'd9, 32'd5, 5'd0, 5'd0, 6'd0, 10'd20));
    step(add_i);
    #1;
    vectors++;
    if (PC_sel !== 1'b1 || jump_address !== 10'd25) begin
      miscompares++;
      $display("FAIL beq_taken: got pcsel=%b jump=%0d, expected 1 25", PC_sel, jump_address);
    end
    step(add_i);
    #1;
    vectors++;
    if (PC_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_bubble_pcsel: got %b expected 0", PC_sel);
    end
    step(nop());
    #1;
    vectors++;
    if (reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL squash_first: got we=%b expected 0", reg_write);
    end
    step(nop());
    #1;
    vectors++;
    if (reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL squash_second: got we=%b expected 0", reg_write);
    end
  endtask

  task automatic test_bne_not_taken();
    step(mk(4'b0001, 4'b1001, 2'b00, 32'd9, 32'd9, 32'd5, 5'd0, 5'd0, 6'd0, 10'd20));
    step(mk(4'b1010, 4'b0, 2'b10, 32'd5, 32'd7, 32'd0, 5'd0, 5'd4, 6'h20, 10'd0));
    #1;
    vectors++;
    if (PC_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL bne_not_taken: got pcsel=%b expected 0", PC_sel);
    end
    step(nop());
    step(nop());
    #1;
    vectors++;
    if (busw !== 32'd12 || rw !== 5'd4 || reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL bne_follow_add: got busw=%0d rw=%0d we=%b, expected 12 4 1", busw, rw, reg_write);
    end
  endtask

  task automatic test_target_wrap();
    step(mk(4'b0001, 4'b1000, 2'b00, 32'd1, 32'd1, 32'd10, 5'd0, 5'd0, 6'd0, 10'd1020));
    step(nop());
    #1;
    vectors++;
    if (PC_sel !== 1'b1 || jump_address !== 10'd6) begin
      miscompares++;
      $display("FAIL target_wrap: got pcsel=%b jump=%0d, expected 1 6", PC_sel, jump_address);
    end
    step(nop());
    step(nop());
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    logic [5:0] fsel[6];
    fsel = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
    i = mk(4'b0, 4'b0, 2'b0, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
           6'($urandom), 10'($urandom));
    case ($urandom_range(0, 7))
      0: begin i.ex = 4'b1010; i.wb = 2'b10; i.funct = fsel[$urandom_range(0, 5)]; end
      1: begin i.ex = 4'b0100; i.wb = 2'b10; end
      2: begin i.ex = 4'b0111; i.wb = 2'b10; end
      3: begin
        i.ex = 4'b0100; i.m = 4'b0010;
        i.a = 32'($urandom_range(0, 15) + 256 * $urandom_range(0, 3));
        i.imm = 32'($urandom_range(0, 15));
      end
      4: begin
        i.ex = 4'b0100; i.m = 4'b0100; i.wb = 2'b11;
        i.a = 32'($urandom_range(0, 15) + 256 * $urandom_range(0, 3));
        i.imm = 32'($urandom_range(0, 15));
      end
      5, 6: begin
        i.ex = 4'b0001; i.m = {3'b100, 1'($urandom)};
        if ($urandom_range(0, 1) == 1) i.b = i.a;
      end
      default: ;
    endcase
    return i;
  endfunction

  task automatic test_random();
    rec_t w, e;
    logic [31:0] exp_busw;
    for (int n = 0; n < 400; n++) begin
      step(rand_ins());
      #1;
      w = q[0];
      e = q[1];
      vectors++;
      if (reg_write !== (w.we && !w.sq)) begin
        miscompares++;
        $display("FAIL rand_we[%0d]: got %b expected %b", n, reg_write, w.we && !w.sq);
      end
      if (w.we && !w.sq && (!w.to_reg || w.ld_ok)) begin
        exp_busw = w.to_reg ? w.ld : w.res;
        vectors++;
        if (busw !== exp_busw || rw !== w.dest) begin
          miscompares++;
          $display("FAIL rand_wb[%0d]: got busw=%h rw=%0d expected busw=%h rw=%0d",
                   n, busw, rw, exp_busw, w.dest);
        end
      end
      vectors++;
      if (PC_sel !== (e.taken && !e.sq)) begin
        miscompares++;
        $display("FAIL rand_pcsel[%0d]: got %b expected %b", n, PC_sel, e.taken && !e.sq);
      end
      if (!e.sq) begin
        vectors++;
        if (jump_address !== e.target) begin
          miscompares++;
          $display("FAIL rand_jump[%0d]: got %0d expected %0d", n, jump_address, e.target);
        end
      end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_rtype();
    test_store_load();
    test_branch_taken();
    test_bne_not_taken();
    test_target_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_writeback.md
Name: execute_writeback

Overview:
- Back half of the MIPS/DLX pipeline: the EX, MEM and WB stages.
- Consumes decode-stage outputs: control bundles, busa, busb, immed_ext, register specifiers and PC_plus_1.
- Returns to the front end the register-file write port (busw, rw, reg_write) and the branch redirect (PC_sel, jump_address).
- Contains the ID/EX, EX/MEM and MEM/WB pipeline registers, the ALU and a word-addressed data memory.

Parameters:
DMEM_ADDR_W, 8, data memory address width in words (depth 2**DMEM_ADDR_W)
PC_W, 10, program counter / jump address width

Ports:
clock  input  1  pipeline clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all pipeline registers
EX_control  input  4  {RegDst, ALUSrc, ALUOp[1:0]}
M_control  input  4  {Branch, MemRead, MemWrite, BOP}; BOP=0 beq, BOP=1 bne
WB_control  input  2  {RegWrite, MemtoReg}
busa  input  32  rs operand
busb  input  32  rt operand / store data
immed_ext  input  32  sign-extended immediate
rt  input  5  instruction rt field
rd  input  5  instruction rd field
funct  input  6  instruction funct field
PC_plus_1  input  PC_W  PC+1 of the decoding instruction
busw  output  32  write-back data to register file
rw  output  5  write-back register index
reg_write  output  1  register-file write enable
PC_sel  output  1  1 = front end loads jump_address
jump_address  output  PC_W  branch target

Behaviour:
- Reset: async, active-high. All ID/EX, EX/MEM and MEM/WB fields go to 0, so busw=0, rw=0, reg_write=0, PC_sel=0, jump_address=0. Data memory contents are not reset.
- Latency: an instruction captured into ID/EX at edge N reaches EX/MEM at N+1 and MEM/WB at N+2. busw, rw and reg_write are valid during cycle N+2; the register file writes at edge N+3.
- No forwarding and no stalls. Software inserts NOPs for data hazards.
- EX stage, combinational from ID/EX:
  - B operand = ALUSrc ? imm : busb.
  - Destination = RegDst ? rd : rt.
  - ALUOp 00 = add; 01 = sub; 11 = or.
  - ALUOp 10 decodes funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1 or 0). Any other funct gives result 0.
  - Arithmetic is 32-bit wrap, no overflow trap.
  - zero = (result == 0).
  - target = PC_plus_1 + imm[PC_W-1:0], mod 2**PC_W.
- EX/MEM register holds: M and WB controls, ALU result, zero, store data (busb), destination, target.
- MEM stage:
  - PC_sel = Branch & (zero ^ BOP), combinational from EX/MEM.
  - jump_address = EX/MEM target (driven regardless of PC_sel).
  - Memory address = result[DMEM_ADDR_W-1:0]; upper bits are ignored, so addresses wrap.
  - MemWrite writes store data at the rising edge.
  - MemRead captures mem[addr] into MEM/WB at the same edge (synchronous read).
- WB stage: busw = MemtoReg ? mem data : ALU result. rw and reg_write come straight from MEM/WB.
- Taken-branch flush: at the edge where PC_sel=1, both ID/EX and EX/MEM load all-zero controls (bubbles). This squashes the two younger instructions. The branch itself proceeds to MEM/WB normally.
- Flush takes priority over normal capture. A branch in a squashed slot never redirects.
- An all-zero control bundle is a bubble: no write, no branch, no memory access.
- Reset asserted mid-operation clears everything immediately; in-flight stores that have not reached the edge are lost.

Decomposition:
- Shared package mips_dlx_pkg holds:
  - bit positions of EX_control, M_control and WB_control;
  - ALUOp codes and funct codes;
  - the zero/bubble control constant.
- One sub-module, alu_dlx: combinational; inputs a, b, ALUOp, funct; outputs result and zero.
- Pipeline registers and memory stay in the top module.

Test Plan:
- Reset: hold reset with random inputs -> busw=0, rw=0, reg_write=0, PC_sel=0 immediately, not at a clock edge.
- R-type add: busa=5, busb=7, funct=0x20, EX=1010, WB=10, rd=3 -> two edges later busw=12, rw=3, reg_write=1. Repeat with funct=0x2A, busa=-1, busb=1 -> busw=1.
- Store then load: sw (ALUSrc, MemWrite) with busa=4, imm=0, busb=0xDEADBEEF. After 2 NOPs, lw (MemRead, WB=11) from the same address -> busw=0xDEADBEEF. Repeat with address 4+256 -> hits the same word (wrap).
- beq taken: busa=busb=9, PC_plus_1=20, imm=5, M=1000 -> PC_sel=1 one cycle after capture, jump_address=25. The two following instructions with RegWrite set produce no reg_write.
- bne not taken: busa=busb=9, M=1001 -> PC_sel=0 and no flush. The following add writes back normally.
- Target wrap: PC_plus_1=1020, imm=10, taken -> jump_address=6.
